mnist_pool_binarizer: RTL and testbench
=======================================

Name: mnist_pool_binarizer

Overview:
Upstream preprocessing stage for the 4-class gate-network classifier, which is combinational, takes a 49-bit input and produces a 4-bit output. Accepts a raster-order stream of 8-bit grayscale pixels from a 28x28 image over a valid/ready handshake. Sum-pools each 4x4 block and thresholds each block sum to one bit. Emits one 49-bit binarized 7x7 frame per image from a single-entry output register, which feeds the classifier's in_bits directly.

Parameters:
IMG_W, 28, pixels per row; must be a multiple of POOL
IMG_H, 28, rows per frame; must be a multiple of POOL
POOL, 4, pooling window edge
PIX_W, 8, pixel width
THRESH, 2048, block-sum threshold; bit = 1 iff sum >= THRESH

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  pixel valid
in_ready  out  1  pixel accepted when in_valid && in_ready
in_pixel  in  PIX_W  grayscale pixel, raster order (row-major, col 0 first)
in_sof  in  1  start-of-frame marker, sampled with the accepted pixel
out_valid  out  1  frame available
out_ready  in  1  consumer accepts frame when out_valid && out_ready
out_bits  out  49  binarized frame; bit index = block_row*7 + block_col
frame_err  out  1  one-cycle pulse on a misplaced in_sof

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_bits=0, frame_err=0.
  - All position counters=0, accumulators=0, shadow frame=0.
- Position tracking:
  - col 0..IMG_W-1 and row 0..IMG_H-1 advance on each accepted pixel only.
  - Block column/row and in-block offsets are tracked with separate counters. No dividers.
- Accumulator bank:
  - 7 accumulators (IMG_W/POOL), width ACC_W = PIX_W + 2*log2(POOL) = 12 bits. No overflow is possible (max 16*255 = 4080).
  - An accepted pixel at in-block offset (0,0) loads acc[bc] = pixel. Any other offset adds: acc[bc] += pixel.
  - At in-block offset (POOL-1, POOL-1): sum = acc[bc] + pixel (unsigned, ACC_W bits). shadow[br*7+bc] is written with (sum >= THRESH) in that same cycle.
- Frame completion:
  - Accepting the pixel at (IMG_H-1, IMG_W-1) loads out_bits with the shadow, including the bit computed in that same cycle, and sets out_valid on the next edge. Latency: out_valid is high one cycle after the last-pixel handshake.
  - Counters wrap to (0,0) and the next frame streams immediately.
- Output handshake:
  - out_bits is stable while out_valid && !out_ready.
  - If the output is consumed and a new frame is loaded in the same cycle, the load wins and out_valid stays 1.
  - If the output is consumed with no load, out_valid=0 next cycle. out_bits holds its last value.
- Backpressure:
  - in_ready = !(pos==last && out_valid && !out_ready). This is combinational from out_ready.
  - in_ready is 1 at every other position, so a second frame may fill the shadow while the first is held.
- in_sof handling:
  - in_sof=1 accepted at (0,0): normal.
  - in_sof=0 at (0,0): allowed (free-running stream).
  - in_sof=1 accepted at any other position:
    - frame_err pulses high for the following cycle.
    - The partial frame is discarded and the pixel is treated as position (0,0), i.e. acc loads.
    - out_valid and out_bits are unaffected.
  - in_sof is ignored when not handshaken.
- Reset mid-frame: everything returns to the reset values. A held output frame is lost. The next accepted pixel is (0,0).
- in_pixel and in_sof are don't-care when in_valid=0.

Decomposition:
- Package mnist_pre_pkg holds:
  - Constants IMG_W, IMG_H, POOL, PIX_W, OUT_W=49.
  - Derived constants BLK_W = IMG_W/POOL and ACC_W.
  - Typedef for the accumulator word and the 49-bit frame vector.
- One sub-module, mnist_raster_counter:
  - Inputs: step, sof_restart.
  - Outputs: col-in-block, row-in-block, block col, block row, and the flags blk_first, blk_last, frame_last.
- The top level holds the accumulator bank, the shadow register, the output register and the handshake.

Test Plan:
- All-zero frame (784 pixels of 0), out_ready=1 -> one out_valid pulse, out_bits = 0. All-255 frame -> out_bits = 49'h1_FFFF_FFFF_FFFF.
- Threshold boundary:
  - Block (0,0) all 128, rest 0 -> out_bits = 49'h1 (sum 2048).
  - Block (0,0) all 127 -> out_bits = 0 (sum 2032).
  - Block (6,6) all 128 -> only bit 48 set.
- Block checkerboard: blocks with (br+bc) even = 255, odd = 0 -> even-parity bit pattern. Check the bit index mapping br*7+bc for all 49 positions.
- Backpressure: hold out_ready=0 after frame A and stream frame B.
  - in_ready is 0 only while frame B's pixel 783 is presented.
  - out_bits stays equal to A.
  - Raising out_ready for 1 cycle -> B loads the next cycle with out_valid continuously 1.
- in_sof on pixel index 100 of a frame:
  - frame_err pulses for exactly 1 cycle.
  - The following 783 pixels plus that pixel form one frame, matching a golden model.
  - No out_valid is produced for the aborted frame.
- Assert rst_n=0 asynchronously mid-frame (pixel 400) with out_valid=1:
  - All outputs are 0 immediately.
  - A fresh 784-pixel frame after release produces the correct out_bits.

Source files
------------

// File: rtl/mnist_pre_pkg.sv
// Shared constants and types for the MNIST pooling/binarizing front end.
// Geometry is fixed here so every stage agrees on frame and block sizes.
package mnist_pre_pkg;

    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int POOL   = 4;
    localparam int PIX_W  = 8;
    localparam int THRESH = 2048;

    localparam int BLK_W  = IMG_W / POOL;
    localparam int BLK_H  = IMG_H / POOL;
    localparam int OUT_W  = BLK_W * BLK_H;
    localparam int ACC_W  = PIX_W + 2 * $clog2(POOL);

    localparam int OFF_W  = $clog2(POOL);
    localparam int BC_W   = $clog2(BLK_W);
    localparam int BR_W   = $clog2(BLK_H);
    localparam int IDX_W  = $clog2(OUT_W);

    typedef logic [ACC_W-1:0] acc_t;
    typedef logic [OUT_W-1:0] frame_t;

    // Bit position of a block inside the binarized frame (row-major).
    function automatic logic [IDX_W-1:0] blk_index(input logic [BR_W-1:0] br,
                                                   input logic [BC_W-1:0] bc);
        return IDX_W'(br) * IDX_W'(BLK_W) + IDX_W'(bc);
    endfunction

endpackage

// File: rtl/mnist_raster_counter.sv
// Raster position tracker split into in-block offsets and block coordinates,
// so the pooling stage never needs to divide a pixel column or row.
module mnist_raster_counter
    import mnist_pre_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_i,
    input  logic             sof_restart_i,
    output logic [OFF_W-1:0] col_in_blk_o,
    output logic [OFF_W-1:0] row_in_blk_o,
    output logic [BC_W-1:0]  blk_col_o,
    output logic [BR_W-1:0]  blk_row_o,
    output logic             blk_first_o,
    output logic             blk_last_o,
    output logic             frame_last_o
);

    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(POOL - 1);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BLK_W - 1);
    localparam logic [BR_W-1:0]  BR_LAST  = BR_W'(BLK_H - 1);

    logic [OFF_W-1:0] cib_q, cib_d, cib_b;
    logic [OFF_W-1:0] rib_q, rib_d, rib_b;
    logic [BC_W-1:0]  bc_q, bc_d, bc_b;
    logic [BR_W-1:0]  br_q, br_d, br_b;

    // A restart treats the current pixel as (0,0), so advance from the origin.
    always_comb begin
        cib_b = sof_restart_i ? '0 : cib_q;
        rib_b = sof_restart_i ? '0 : rib_q;
        bc_b  = sof_restart_i ? '0 : bc_q;
        br_b  = sof_restart_i ? '0 : br_q;
        cib_d = cib_b;
        rib_d = rib_b;
        bc_d  = bc_b;
        br_d  = br_b;
        if (cib_b != OFF_LAST) begin
            cib_d = cib_b + OFF_W'(1);
        end else begin
            cib_d = '0;
            if (bc_b != BC_LAST) begin
                bc_d = bc_b + BC_W'(1);
            end else begin
                bc_d = '0;
                if (rib_b != OFF_LAST) begin
                    rib_d = rib_b + OFF_W'(1);
                end else begin
                    rib_d = '0;
                    br_d  = (br_b == BR_LAST) ? '0 : br_b + BR_W'(1);
                end
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cib_q <= '0;
            rib_q <= '0;
            bc_q  <= '0;
            br_q  <= '0;
        end else if (step_i) begin
            cib_q <= cib_d;
            rib_q <= rib_d;
            bc_q  <= bc_d;
            br_q  <= br_d;
        end
    end

    assign col_in_blk_o = cib_q;
    assign row_in_blk_o = rib_q;
    assign blk_col_o    = bc_q;
    assign blk_row_o    = br_q;
    assign blk_first_o  = (cib_q == '0) && (rib_q == '0);
    assign blk_last_o   = (cib_q == OFF_LAST) && (rib_q == OFF_LAST);
    assign frame_last_o = blk_last_o && (bc_q == BC_LAST) && (br_q == BR_LAST);

endmodule

// File: rtl/mnist_pool_binarizer.sv
// Sum-pools a 28x28 pixel stream in 4x4 blocks and thresholds each block,
// presenting one 49-bit binarized frame per image from a held output register.
module mnist_pool_binarizer
    import mnist_pre_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_bits,
    output logic             frame_err
);

    logic [OFF_W-1:0] col_in_blk, row_in_blk;
    logic [BC_W-1:0]  blk_col, bc_eff;
    logic [BR_W-1:0]  blk_row, br_eff;
    logic             blk_first, blk_last, frame_last;
    logic             accept, at_origin, sof_restart;
    logic             blk_first_eff, blk_last_eff, frame_last_eff;

    acc_t             acc_q [BLK_W];
    acc_t             acc_sel, sum;
    logic             hit;
    frame_t           shadow_q, shadow_d;
    frame_t           out_bits_q;
    logic             out_valid_q;
    logic             frame_err_q;

    mnist_raster_counter u_cnt (
        .clk           (clk),
        .rst_n         (rst_n),
        .step_i        (accept),
        .sof_restart_i (sof_restart),
        .col_in_blk_o  (col_in_blk),
        .row_in_blk_o  (row_in_blk),
        .blk_col_o     (blk_col),
        .blk_row_o     (blk_row),
        .blk_first_o   (blk_first),
        .blk_last_o    (blk_last),
        .frame_last_o  (frame_last)
    );

    // Stall only the last pixel of a frame while the previous frame is still held.
    assign in_ready = !(frame_last && out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;

    assign at_origin   = (col_in_blk == '0) && (row_in_blk == '0) &&
                         (blk_col == '0) && (blk_row == '0);
    assign sof_restart = in_sof && !at_origin;

    // Effective position of the presented pixel once a misplaced SOF is honoured.
    assign bc_eff         = sof_restart ? '0 : blk_col;
    assign br_eff         = sof_restart ? '0 : blk_row;
    assign blk_first_eff  = blk_first || sof_restart;
    assign blk_last_eff   = blk_last && !sof_restart;
    assign frame_last_eff = frame_last && !sof_restart;

    assign acc_sel = acc_q[bc_eff];
    assign sum     = acc_sel + ACC_W'(in_pixel);
    assign hit     = (sum >= ACC_W'(THRESH));

    always_comb begin
        shadow_d = shadow_q;
        if (accept && blk_last_eff) begin
            shadow_d[blk_index(br_eff, bc_eff)] = hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the accumulator bank is small and must read as zero after
            // reset, so it is reset explicitly rather than left to a RAM.
            for (int i = 0; i < BLK_W; i++) begin
                acc_q[i] <= '0;
            end
            shadow_q    <= '0;
            out_bits_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= accept && sof_restart;
            if (accept) begin
                acc_q[bc_eff] <= blk_first_eff ? ACC_W'(in_pixel) : sum;
            end
            shadow_q <= shadow_d;
            if (accept && frame_last_eff) begin
                out_bits_q  <= shadow_d;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_bits  = out_bits_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_mnist_pool_binarizer.sv
// Scoreboard bench: stimulus pushes expected frames, a negedge monitor pops
// and compares them whenever the DUT hands a frame to the consumer.
module tb_mnist_pool_binarizer;
    import mnist_pre_pkg::*;

    localparam int NPIX = IMG_W * IMG_H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_pixel = '0;
    logic        in_sof = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [48:0] out_bits;
    logic        frame_err;

    int          checks = 0;
    int          failures = 0;
    int          stalls = 0;
    int          err_pulses = 0;
    logic [48:0] exp_q [$];
    logic [7:0]  img [NPIX];

    localparam logic [48:0] FR_ZERO   = 49'h0;
    localparam logic [48:0] FR_ONES   = 49'h1_FFFF_FFFF_FFFF;
    localparam logic [48:0] FR_B00    = 49'h0_0000_0000_0001;
    localparam logic [48:0] FR_B66    = 49'h1_0000_0000_0000;
    localparam logic [48:0] FR_CHECK  = 49'h1_5555_5555_5555;
    localparam logic [48:0] FR_B32    = 49'h0_0000_0080_0000;

    always #5 clk = ~clk;

    mnist_pool_binarizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .in_sof    (in_sof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits),
        .frame_err (frame_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_frame", 64'(out_valid), 64'(0));
            else                   check("frame_bits", 64'(out_bits), 64'(exp_q.pop_front()));
        end
        if (rst_n && frame_err) err_pulses++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_pixel(input logic [7:0] p, input logic sof);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_pixel = p;
        in_sof   = sof;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            stalls++;
            guard++;
            @(negedge clk);
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_range(input int first, input int last, input logic sof_first);
        for (int i = first; i <= last; i++) send_pixel(img[i], sof_first && (i == first));
    endtask

    task automatic fill_all(input logic [7:0] v);
        for (int i = 0; i < NPIX; i++) img[i] = v;
    endtask

    task automatic fill_block(input int br, input int bc, input logic [7:0] v);
        for (int r = 0; r < POOL; r++)
            for (int c = 0; c < POOL; c++)
                img[(br * POOL + r) * IMG_W + bc * POOL + c] = v;
    endtask

    function automatic logic [48:0] model_frame();
        logic [48:0] f;
        int s;
        f = '0;
        for (int br = 0; br < 7; br++)
            for (int bc = 0; bc < 7; bc++) begin
                s = 0;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        s += int'(img[(br * 4 + r) * 28 + bc * 4 + c]);
                f[br * 7 + bc] = (s >= 2048);
            end
        return f;
    endfunction

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("scoreboard_drain", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic fill_checker();
        for (int br = 0; br < 7; br++)
            for (int bc = 0; bc < 7; bc++)
                fill_block(br, bc, ((br + bc) % 2 == 0) ? 8'd255 : 8'd0);
    endtask

    initial begin
        int e0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_bits", 64'(out_bits), 64'(0));
        check("rst_frame_err", 64'(frame_err), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        // Directed frames with hand-computed results.
        fill_all(8'd0);   exp_q.push_back(FR_ZERO);  send_range(0, NPIX - 1, 1'b1); drain();
        fill_all(8'd255); exp_q.push_back(FR_ONES);  send_range(0, NPIX - 1, 1'b1); drain();
        fill_all(8'd0); fill_block(0, 0, 8'd128); exp_q.push_back(FR_B00);  send_range(0, NPIX - 1, 1'b1);
        fill_all(8'd0); fill_block(0, 0, 8'd127); exp_q.push_back(FR_ZERO); send_range(0, NPIX - 1, 1'b0);
        fill_all(8'd0); fill_block(6, 6, 8'd128); exp_q.push_back(FR_B66);  send_range(0, NPIX - 1, 1'b1);
        fill_checker(); exp_q.push_back(FR_CHECK); send_range(0, NPIX - 1, 1'b1);
        drain();
        check("no_spurious_frame_err", 64'(err_pulses), 64'(0));

        // Backpressure: hold frame A while frame B streams in behind it.
        out_ready = 1'b0;
        exp_q.push_back(FR_CHECK);
        send_range(0, NPIX - 1, 1'b1);
        check("bp_a_valid", 64'(out_valid), 64'(1));
        fill_all(8'd0); fill_block(3, 2, 8'd200);
        stalls = 0;
        send_range(0, NPIX - 2, 1'b1);
        check("bp_no_stall", 64'(stalls), 64'(0));
        in_valid = 1'b1; in_pixel = img[NPIX - 1]; in_sof = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready_low", 64'(in_ready), 64'(0));
            check("bp_hold_valid", 64'(out_valid), 64'(1));
            check("bp_hold_bits", 64'(out_bits), 64'(FR_CHECK));
        end
        exp_q.push_back(FR_B32);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1 out_ready = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("bp_b_valid", 64'(out_valid), 64'(1));
        check("bp_b_bits", 64'(out_bits), 64'(FR_B32));
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Misplaced SOF at pixel 100 aborts the partial frame.
        fill_all(8'd255);
        send_range(0, 99, 1'b1);
        for (int i = 0; i < NPIX; i++) img[i] = 8'((i * 7 + (i / 28) * 13) % 256);
        exp_q.push_back(model_frame());
        e0 = err_pulses;
        send_range(0, NPIX - 1, 1'b1);
        drain();
        check("sof_err_pulses", 64'(err_pulses - e0), 64'(1));

        // Asynchronous reset mid-frame with a held output.
        out_ready = 1'b0;
        fill_all(8'd255);
        send_range(0, NPIX - 1, 1'b1);
        check("rst2_pre_valid", 64'(out_valid), 64'(1));
        send_range(0, 399, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check("rst2_out_valid", 64'(out_valid), 64'(0));
        check("rst2_out_bits", 64'(out_bits), 64'(0));
        check("rst2_frame_err", 64'(frame_err), 64'(0));
        check("rst2_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1 rst_n = 1'b1; out_ready = 1'b1;
        fill_checker();
        exp_q.push_back(FR_CHECK);
        send_range(0, NPIX - 1, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
